// File: rtl/sync_fifo_rewind.sv
// Synchronous FIFO with automatic pointers, status flags, sticky error bits and mark/rewind replay.
// Entries between the mark and the read pointer stay protected until the mark is released.
module sync_fifo_rewind #(
  parameter int unsigned WIDTH     = 9,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clr,
  input  logic                     i_write,
  input  logic [WIDTH-1:0]         i_data_in,
  input  logic                     i_read,
  output logic [WIDTH-1:0]         o_data_out,
  input  logic                     i_mark,
  input  logic                     i_rewind,
  input  logic                     i_mark_clr,
  input  logic                     i_err_clr,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_almost_full,
  output logic                     o_almost_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic                     o_underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne  = (AW+1)'(1);
  localparam logic [AW:0] DepthP  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AfTh    = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AeTh    = (AW+1)'(AE_THRESH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      r_mark_ptr;
  logic             r_mark_valid;
  logic [WIDTH-1:0] r_data_out;
  logic             r_overflow;
  logic             r_underflow;

  logic [AW:0] w_count;
  logic [AW:0] w_base;
  logic [AW:0] w_used;
  logic        w_full;
  logic        w_empty;
  logic        w_rewind;
  logic        w_wr_acc;
  logic        w_rd_acc;
  logic        w_ovf_evt;
  logic        w_unf_evt;

  always_comb begin
    w_count   = r_wr_ptr - r_rd_ptr;
    w_base    = r_mark_valid ? r_mark_ptr : r_rd_ptr;
    w_used    = r_wr_ptr - w_base;
    w_full    = (w_used == DepthP);
    w_empty   = (w_count == '0);
    w_rewind  = i_rewind & r_mark_valid;
    // Requests are judged against start-of-cycle flags; Clr swallows them entirely.
    w_wr_acc  = ~i_clr & i_write & ~w_full;
    w_ovf_evt = ~i_clr & i_write & w_full;
    w_rd_acc  = ~i_clr & i_read & ~w_empty & ~i_rewind;
    w_unf_evt = ~i_clr & i_read & w_empty & ~i_rewind;
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data_in;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_mark_ptr   <= '0;
      r_mark_valid <= 1'b0;
      r_data_out   <= '0;
    end else if (i_clr) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_mark_ptr   <= '0;
      r_mark_valid <= 1'b0;
      r_data_out   <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PtrOne;
      end
      if (w_rd_acc) begin
        r_data_out <= r_mem[r_rd_ptr[AW-1:0]];
        r_rd_ptr   <= r_rd_ptr + PtrOne;
      end
      if (w_rewind) begin
        r_rd_ptr <= r_mark_ptr;
      end else if (i_mark) begin
        r_mark_ptr   <= r_rd_ptr;
        r_mark_valid <= 1'b1;
      end else if (i_mark_clr) begin
        r_mark_valid <= 1'b0;
      end
    end
  end

  // A fresh error event outranks ErrClr in the same cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_ovf_evt | (r_overflow & ~i_err_clr);
      r_underflow <= w_unf_evt | (r_underflow & ~i_err_clr);
    end
  end

  assign o_data_out     = r_data_out;
  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_almost_full  = (w_used >= AfTh);
  assign o_almost_empty = (w_count <= AeTh);
  assign o_count        = w_count;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_rewind.sv
// Directed bench for sync_fifo_rewind at DEPTH=4: fill/drain, errors, mark/rewind, wrap and reset.
module tb_sync_fifo_rewind;

  localparam int unsigned WIDTH = 9;
  localparam int unsigned DEPTH = 4;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b0;
  logic             i_clr = 1'b0;
  logic             i_write = 1'b0;
  logic [WIDTH-1:0] i_data_in = '0;
  logic             i_read = 1'b0;
  logic [WIDTH-1:0] o_data_out;
  logic             i_mark = 1'b0;
  logic             i_rewind = 1'b0;
  logic             i_mark_clr = 1'b0;
  logic             i_err_clr = 1'b0;
  logic             o_full;
  logic             o_empty;
  logic             o_almost_full;
  logic             o_almost_empty;
  logic [2:0]       o_count;
  logic             o_overflow;
  logic             o_underflow;

  int checks = 0;
  int errors = 0;

  sync_fifo_rewind #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(3), .AE_THRESH(1)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(i_clr), .i_write(i_write), .i_data_in(i_data_in),
    .i_read(i_read), .o_data_out(o_data_out), .i_mark(i_mark), .i_rewind(i_rewind),
    .i_mark_clr(i_mark_clr), .i_err_clr(i_err_clr), .o_full(o_full), .o_empty(o_empty),
    .o_almost_full(o_almost_full), .o_almost_empty(o_almost_empty), .o_count(o_count),
    .o_overflow(o_overflow), .o_underflow(o_underflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Hold the current request set across one rising edge, then sample 1 ns later.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_write = 1'b0; i_read = 1'b0; i_mark = 1'b0; i_rewind = 1'b0;
    i_mark_clr = 1'b0; i_err_clr = 1'b0; i_clr = 1'b0;
  endtask

  task automatic wr(input logic [WIDTH-1:0] d);
    idle(); i_write = 1'b1; i_data_in = d; step(); idle();
  endtask

  task automatic rd();
    idle(); i_read = 1'b1; step(); idle();
  endtask

  initial begin
    logic [WIDTH-1:0] fill_vals [4];
    fill_vals[0] = 9'd2; fill_vals[1] = 9'd4; fill_vals[2] = 9'd6; fill_vals[3] = 9'd8;

    i_rst = 1'b1;
    #12;
    i_rst = 1'b0;
    #1;
    check("rst_empty", 32'(o_empty), 1);
    check("rst_ae", 32'(o_almost_empty), 1);
    check("rst_full", 32'(o_full), 0);
    check("rst_af", 32'(o_almost_full), 0);
    check("rst_count", 32'(o_count), 0);
    check("rst_dout", 32'(o_data_out), 0);

    // 1. fill to full, then overflow
    for (int i = 0; i < 4; i++) begin
      wr(fill_vals[i]);
      check("fill_count", 32'(o_count), 32'(i + 1));
      check("fill_af", 32'(o_almost_full), (i >= 2) ? 1 : 0);
      check("fill_full", 32'(o_full), (i == 3) ? 1 : 0);
      check("fill_ae", 32'(o_almost_empty), (i == 0) ? 1 : 0);
    end
    wr(9'd10);
    check("ovf_set", 32'(o_overflow), 1);
    check("ovf_count", 32'(o_count), 4);

    // 2. drain, underflow, error clear
    for (int i = 0; i < 4; i++) begin
      rd();
      check("drain_dout", 32'(o_data_out), 32'(fill_vals[i]));
    end
    check("drain_empty", 32'(o_empty), 1);
    rd();
    check("unf_set", 32'(o_underflow), 1);
    check("unf_dout_hold", 32'(o_data_out), 8);
    idle(); i_err_clr = 1'b1; step(); idle();
    check("errclr_ovf", 32'(o_overflow), 0);
    check("errclr_unf", 32'(o_underflow), 0);

    // 3. mark, read, rewind, re-read
    wr(9'd2);
    wr(9'd4);
    idle(); i_mark = 1'b1; step(); idle();
    rd(); check("mk_rd0", 32'(o_data_out), 2);
    rd(); check("mk_rd1", 32'(o_data_out), 4);
    check("mk_count0", 32'(o_count), 0);
    idle(); i_rewind = 1'b1; i_read = 1'b1; step(); idle();
    check("rew_count", 32'(o_count), 2);
    check("rew_dout_hold", 32'(o_data_out), 4);
    check("rew_no_unf", 32'(o_underflow), 0);
    rd(); check("rew_rd0", 32'(o_data_out), 2);
    rd(); check("rew_rd1", 32'(o_data_out), 4);

    // 4. protected space keeps Full asserted until MarkClr
    wr(9'd20);
    wr(9'd22);
    check("prot_full", 32'(o_full), 1);
    check("prot_count", 32'(o_count), 2);
    wr(9'd99);
    check("prot_ovf", 32'(o_overflow), 1);
    check("prot_count2", 32'(o_count), 2);
    idle(); i_err_clr = 1'b1; i_mark_clr = 1'b1; step(); idle();
    check("mclr_full", 32'(o_full), 0);
    check("mclr_ovf", 32'(o_overflow), 0);
    wr(9'd24);
    check("mclr_wr_count", 32'(o_count), 3);
    rd(); check("prot_rd0", 32'(o_data_out), 20);
    rd(); check("prot_rd1", 32'(o_data_out), 22);
    rd(); check("prot_rd2", 32'(o_data_out), 24);
    check("prot_empty", 32'(o_empty), 1);

    // 5. simultaneous write/read at empty and at full
    idle(); i_write = 1'b1; i_data_in = 9'd30; i_read = 1'b1; step(); idle();
    check("sim_e_count", 32'(o_count), 1);
    check("sim_e_unf", 32'(o_underflow), 1);
    check("sim_e_dout", 32'(o_data_out), 24);
    idle(); i_err_clr = 1'b1; step(); idle();
    wr(9'd32); wr(9'd34); wr(9'd36);
    check("sim_f_full", 32'(o_full), 1);
    idle(); i_write = 1'b1; i_data_in = 9'd38; i_read = 1'b1; step(); idle();
    check("sim_f_dout", 32'(o_data_out), 30);
    check("sim_f_ovf", 32'(o_overflow), 1);
    check("sim_f_count", 32'(o_count), 3);
    rd(); check("sim_rd0", 32'(o_data_out), 32);
    rd(); check("sim_rd1", 32'(o_data_out), 34);
    rd(); check("sim_rd2", 32'(o_data_out), 36);

    // synchronous clear keeps errors
    wr(9'd50);
    idle(); i_clr = 1'b1; i_write = 1'b1; i_data_in = 9'd51; step(); idle();
    check("clr_count", 32'(o_count), 0);
    check("clr_empty", 32'(o_empty), 1);
    check("clr_dout", 32'(o_data_out), 0);
    check("clr_keep_ovf", 32'(o_overflow), 1);

    // 6. streaming across two pointer wraps, then async reset
    rd();
    check("pre_unf", 32'(o_underflow), 1);
    for (int i = 0; i < 20; i++) begin
      wr(9'(i * 3 + 1));
      check("strm_count1", 32'(o_count), 1);
      rd();
      check("strm_dout", 32'(o_data_out), 32'(i * 3 + 1));
      check("strm_empty", 32'(o_empty), 1);
    end
    wr(9'd77);
    wr(9'd78);
    #2;
    i_rst = 1'b1;
    #1;
    check("arst_empty", 32'(o_empty), 1);
    check("arst_count", 32'(o_count), 0);
    check("arst_dout", 32'(o_data_out), 0);
    check("arst_ovf", 32'(o_overflow), 0);
    check("arst_unf", 32'(o_underflow), 0);
    #1;
    i_rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_rewind.md
Name: sync_fifo_rewind

Overview:
- Parametrised synchronous FIFO: successor to the 9-bit, manually-incremented FIFO.
- Pointers advance automatically on accepted Write/Read.
- Provides full/empty/almost flags, an occupancy count and sticky overflow/underflow error bits.
- Mark/Rewind replays already-read data. Used as the packet buffer between the receive framer and the downstream consumer, which may need to re-read a packet.

Parameters:
- WIDTH, 9: data width in bits.
- DEPTH, 16: number of entries; power of 2, at least 2. Let AW = log2(DEPTH).
- AF_THRESH, DEPTH-2: AlmostFull asserts when Used >= AF_THRESH.
- AE_THRESH, 2: AlmostEmpty asserts when Count <= AE_THRESH.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Clr  in  1  synchronous clear: pointers, mark and DataOut return to reset values; errors are kept.
- Write  in  1  write request.
- DataIn  in  WIDTH  write data.
- Read  in  1  read request.
- DataOut  out  WIDTH  registered read data.
- Mark  in  1  capture the current read pointer as the replay point.
- Rewind  in  1  restore the read pointer to the mark.
- MarkClr  in  1  release the mark.
- ErrClr  in  1  clear Overflow and Underflow.
- Full, Empty, AlmostFull, AlmostEmpty  out  1 each  status flags.
- Count  out  AW+1  unread entries.
- Overflow, Underflow  out  1 each  sticky error flags.

Behaviour:
- Pointers: wr_ptr, rd_ptr and mark_ptr are AW+1 bits wide and wrap modulo 2*DEPTH. Memory is addressed by the low AW bits.
- Derived values (all arithmetic mod 2^(AW+1)):
  - Count = wr_ptr - rd_ptr.
  - base = MarkValid ? mark_ptr : rd_ptr.
  - Used = wr_ptr - base.
- Flags are combinational from registered state only, never from same-cycle requests:
  - Full = (Used == DEPTH).
  - Empty = (Count == 0).
  - AlmostFull = (Used >= AF_THRESH).
  - AlmostEmpty = (Count <= AE_THRESH).
- Rst (asynchronous): all pointers 0, MarkValid 0, DataOut 0, Overflow 0, Underflow 0. Outputs are therefore Empty=1, AlmostEmpty=1, Full=0, AlmostFull=0, Count=0.
- Write accept = Write & !Full: mem[wr_ptr] <= DataIn and wr_ptr increments. Write while Full: data dropped, Overflow <= 1.
- Read accept = Read & !Empty & !Rewind:
  - DataOut <= mem[rd_ptr] and rd_ptr increments.
  - Latency: DataOut is valid from the cycle after the accepting edge.
  - DataOut holds its value when no read is accepted.
- Read while Empty (and Rewind low): Underflow <= 1, DataOut holds.
- Simultaneous Write and Read:
  - Both are evaluated against start-of-cycle flags.
  - When Empty, the write is accepted and the read raises Underflow.
  - When Full, the read is accepted and the write raises Overflow.
  - There is no read-through and no write-through.
- Mark: mark_ptr <= rd_ptr (the value before any same-cycle read), MarkValid <= 1.
  - While MarkValid, entries between mark_ptr and rd_ptr are protected: Used includes them, so writes cannot overwrite them.
- Rewind (only when MarkValid): rd_ptr <= mark_ptr; MarkValid stays 1.
  - Any same-cycle Read is ignored with no Underflow and no DataOut change.
  - Rewind with MarkValid=0 is ignored.
- MarkClr: MarkValid <= 0, which frees the protected space from the next cycle.
- Priority per cycle: Clr > Rewind > Mark > MarkClr.
  - Mark with Rewind: the mark is unchanged.
  - Mark with MarkClr: the mark is taken.
- Clr has the same effect as reset, except Overflow and Underflow are kept. Any Write/Read in the same cycle is ignored.
- ErrClr clears both error bits. A new error event in the same cycle wins, leaving the bit set.
- Pointer wrap must be seamless: after 2*DEPTH writes and reads, pointers return to 0 and flags stay correct.

Test Plan (WIDTH=9, DEPTH=4, AF_THRESH=3, AE_THRESH=1):
1. Reset then write 2,4,6,8 on consecutive cycles -> Count 1,2,3,4; AlmostFull on the 3rd write; Full=1 after the 4th; 5th write of 10 -> Overflow=1 and memory unchanged.
2. Read 4 times from full -> DataOut 2,4,6,8, each one cycle after its accepting edge; Empty=1; an extra Read -> Underflow=1, DataOut stays 8; ErrClr -> both error bits 0.
3. Write 2,4, Mark, read both, Rewind, read twice -> DataOut 2,4 then 2,4 again; Count returns to 2 after Rewind.
4. With the mark held at 2 entries read, write until Full -> Full at Used=4 while Count=2; MarkClr -> Full=0 next cycle, and the next write is accepted.
5. Simultaneous Write=1/Read=1 when Empty -> write accepted, Underflow=1, Count=1. When Full -> read accepted, Overflow=1, Count=3.
6. Stream 20 write/read pairs (wraps pointers twice), then assert Rst mid-stream asynchronously -> data matches in order before the reset; immediately after Rst, Empty=1, Count=0, DataOut=0, Overflow and Underflow 0.
